laconic_pe_acc: RTL and testbench

LACONIC_PE_ACC -- requirements
Module: laconic_pe_acc

---
 rtl/laconic_pe_acc.sv | 134 +++++++++++++
 tb/tb_laconic_pe_acc.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laconic_pe_acc.sv
// Laconic-style processing element: sums signed power-of-two term pairs per beat and
// accumulates beats into saturating group results with a valid/ready output handshake.
module laconic_pe_acc #(
  parameter int unsigned LANES = 16,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES-1:0]        in_applied,
  input  logic [LANES*EXP_W-1:0]  t0,
  input  logic [LANES*EXP_W-1:0]  t1,
  input  logic [LANES-1:0]        s0,
  input  logic [LANES-1:0]        s1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_value,
  output logic                    out_overflow
);

  localparam int unsigned MaxExp = 2 * ((1 << EXP_W) - 1);
  localparam int unsigned PW     = MaxExp + 1 + $clog2(LANES) + 1;
  localparam int unsigned SW     = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic signed [SW-1:0] AccMax = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] AccMin = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [PW-1:0] term [LANES];
  logic signed [PW-1:0] partial;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [EXP_W:0] esum;
    logic [PW-1:0]  mag;
    assign esum = {1'b0, t0[i*EXP_W +: EXP_W]} + {1'b0, t1[i*EXP_W +: EXP_W]};
    assign mag  = {{(PW-1){1'b0}}, 1'b1} << esum;
    assign term[i] = !in_applied[i]    ? '0 :
                     (s0[i] ^ s1[i])   ? -$signed(mag) : $signed(mag);
  end

  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      partial = partial + term[i];
    end
  end

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic signed [PW-1:0]    s1_partial_q, s1_partial_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_value_q, out_value_d;
  logic                    out_ovf_q, out_ovf_d;

  logic                    stall, accept;
  logic signed [SW-1:0]    sum_ext;
  logic                    sat_hi, sat_lo;
  logic signed [ACC_W-1:0] sat_val;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Sum is one bit wider than either operand, so the clamp test never wraps.
  assign sum_ext = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                 + {{(SW-PW){s1_partial_q[PW-1]}}, s1_partial_q};
  assign sat_hi  = sum_ext > AccMax;
  assign sat_lo  = sum_ext < AccMin;
  assign sat_val = sat_hi ? AccMax[ACC_W-1:0] :
                   sat_lo ? AccMin[ACC_W-1:0] : sum_ext[ACC_W-1:0];

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    s1_partial_d = s1_partial_q;
    acc_d        = acc_q;
    sticky_d     = sticky_q;
    out_valid_d  = out_valid_q;
    out_value_d  = out_value_q;
    out_ovf_d    = out_ovf_q;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_last_d    = in_last;
        s1_partial_d = partial;
      end
      // Not stalled: any held result is being consumed this edge.
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_valid_d = 1'b1;
          out_value_d = sat_val;
          out_ovf_d   = sticky_q | sat_hi | sat_lo;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = sat_val;
          sticky_d = sticky_q | sat_hi | sat_lo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_partial_q <= '0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_value_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_partial_q <= s1_partial_d;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
      out_valid_q  <= out_valid_d;
      out_value_q  <= out_value_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_laconic_pe_acc.sv
// Directed bench for laconic_pe_acc: a 32-bit and a 16-bit accumulator instance share stimulus;
// a vector table streams groups while hand sequences cover latency, backpressure and reset.
module tb_laconic_pe_acc;
  localparam int LANES = 16;
  localparam int EXP_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, in_valid, in_last, out_ready;
  logic [LANES-1:0]       in_applied, s0, s1;
  logic [LANES*EXP_W-1:0] t0, t1;
  logic                   in_ready32, in_ready16, out_valid32, out_valid16, ovf32, ovf16;
  logic signed [31:0]     out_value32;
  logic signed [15:0]     out_value16;

  laconic_pe_acc #(.LANES(LANES), .EXP_W(EXP_W), .ACC_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_last(in_last),
    .in_applied(in_applied), .t0(t0), .t1(t1), .s0(s0), .s1(s1), .out_valid(out_valid32),
    .out_ready(out_ready), .out_value(out_value32), .out_overflow(ovf32)
  );

  laconic_pe_acc #(.LANES(LANES), .EXP_W(EXP_W), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last),
    .in_applied(in_applied), .t0(t0), .t1(t1), .s0(s0), .s1(s1), .out_valid(out_valid16),
    .out_ready(out_ready), .out_value(out_value16), .out_overflow(ovf16)
  );

  typedef struct {
    logic [LANES-1:0]       applied;
    logic [LANES*EXP_W-1:0] t0;
    logic [LANES*EXP_W-1:0] t1;
    logic [LANES-1:0]       s0;
    logic [LANES-1:0]       s1;
    logic                   last;
    int                     gap;
    int                     exp32;
    int                     exp16;
    bit                     ovf16;
  } vec_t;

  typedef struct {
    int v32;
    int v16;
    bit o16;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t expq[$];
  exp_t me;
  bit   mon_en = 1'b0;
  vec_t vq[$];
  vec_t v;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Unapplied lanes carry nonzero exponents/signs so gating is exercised.
  function automatic vec_t blank(input logic last);
    vec_t r;
    r.applied = '0;
    r.t0 = {LANES{3'd7}};
    r.t1 = {LANES{3'd3}};
    r.s0 = 16'hA5A5;
    r.s1 = 16'h0F0F;
    r.last = last;
    r.gap = 0;
    r.exp32 = 0;
    r.exp16 = 0;
    r.ovf16 = 1'b0;
    return r;
  endfunction

  // Negative terms alternate which sign input is set; some positives set both.
  function automatic vec_t add_term(input vec_t vi, input int lane, input int e, input bit neg);
    vec_t r;
    int   a;
    r = vi;
    a = (e > 7) ? 7 : e;
    r.applied[lane] = 1'b1;
    r.t0[lane*EXP_W +: EXP_W] = 3'(a);
    r.t1[lane*EXP_W +: EXP_W] = 3'(e - a);
    if (neg) begin
      r.s0[lane] = (lane % 2 == 1);
      r.s1[lane] = (lane % 2 == 0);
    end else begin
      r.s0[lane] = (lane % 3 == 0);
      r.s1[lane] = (lane % 3 == 0);
    end
    return r;
  endfunction

  function automatic vec_t with_exp(input vec_t vi, input int e32, input int e16, input bit o16);
    vec_t r;
    r = vi;
    r.exp32 = e32;
    r.exp16 = e16;
    r.ovf16 = o16;
    return r;
  endfunction

  function automatic vec_t b856(input logic last);
    vec_t r;
    r = add_term(blank(last), 0, 9, 1'b0);
    r = add_term(r, 3, 8, 1'b0);
    r = add_term(r, 6, 6, 1'b0);
    r = add_term(r, 9, 4, 1'b0);
    r = add_term(r, 12, 3, 1'b0);
    return with_exp(r, 856, 856, 1'b0);
  endfunction

  function automatic vec_t b8752(input logic last);
    vec_t r;
    r = add_term(blank(last), 1, 13, 1'b0);
    r = add_term(r, 5, 9, 1'b0);
    r = add_term(r, 10, 5, 1'b0);
    r = add_term(r, 15, 4, 1'b0);
    return with_exp(r, 8752, 8752, 1'b0);
  endfunction

  function automatic vec_t bm6792(input logic last);
    vec_t r;
    r = add_term(blank(last), 2, 12, 1'b1);
    r = add_term(r, 4, 11, 1'b1);
    r = add_term(r, 7, 9, 1'b1);
    r = add_term(r, 11, 7, 1'b1);
    r = add_term(r, 13, 3, 1'b1);
    return with_exp(r, -6792, -6792, 1'b0);
  endfunction

  function automatic vec_t b1024(input logic last);
    vec_t r;
    r = add_term(blank(last), 15, 10, 1'b0);
    r.t0[15*EXP_W +: EXP_W] = 3'd5;
    r.t1[15*EXP_W +: EXP_W] = 3'd5;
    r.s0[15] = 1'b0;
    r.s1[15] = 1'b0;
    return with_exp(r, 1024, 1024, 1'b0);
  endfunction

  function automatic vec_t b_all14(input logic last, input bit neg);
    vec_t r;
    r = blank(last);
    for (int i = 0; i < LANES; i++) r = add_term(r, i, 14, neg);
    return r;
  endfunction

  task automatic apply(input vec_t a);
    in_applied = a.applied;
    t0 = a.t0;
    t1 = a.t1;
    s0 = a.s0;
    s1 = a.s1;
    in_last = a.last;
    in_valid = 1'b1;
  endtask

  task automatic push_exp(input vec_t a);
    exp_t x;
    x.v32 = a.exp32;
    x.v16 = a.exp16;
    x.o16 = a.ovf16;
    expq.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && out_ready && (out_valid32 || out_valid16)) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: out_valid=1 value=%0d, expected no result", out_value32);
      end else begin
        me = expq.pop_front();
        chk("valid32", out_valid32, 1);
        chk("valid16", out_valid16, 1);
        chk("value32", out_value32, me.v32);
        chk("ovf32", ovf32, 0);
        chk("value16", out_value16, me.v16);
        chk("ovf16", ovf16, me.o16);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    in_applied = '0;
    t0 = '0;
    t1 = '0;
    s0 = '0;
    s1 = '0;

    // Vector table
    vq.push_back(b856(1'b0));
    vq.push_back(b8752(1'b0));
    vq.push_back(with_exp(bm6792(1'b1), 2816, 2816, 1'b0));
    vq.push_back(b856(1'b1));
    vq.push_back(bm6792(1'b1));
    vq.push_back(blank(1'b1));
    v = add_term(blank(1'b1), 0, 0, 1'b0);
    vq.push_back(with_exp(add_term(v, 3, 14, 1'b0), 16385, 16385, 1'b0));
    vq.push_back(with_exp(b_all14(1'b1, 1'b1), -262144, -32768, 1'b1));
    vq.push_back(b_all14(1'b0, 1'b0));
    vq.push_back(with_exp(b_all14(1'b1, 1'b0), 524288, 32767, 1'b1));
    vq.push_back(b1024(1'b1));
    vq.push_back(b856(1'b0));
    v = b8752(1'b1);
    v.gap = 3;
    vq.push_back(with_exp(v, 9608, 9608, 1'b0));
    v = add_term(blank(1'b1), 0, 14, 1'b0);
    vq.push_back(add_term(v, 1, 14, 1'b1));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid32", out_valid32, 0);
    chk("rst_value32", out_value32, 0);
    chk("rst_ovf32", ovf32, 0);
    chk("rst_valid16", out_valid16, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready32", in_ready32, 1);
    chk("rst_in_ready16", in_ready16, 1);

    // Latency: single beat on lane 15
    apply(b1024(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge1_valid", out_valid32, 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", out_valid32, 1);
    chk("lat_value", out_value32, 1024);
    chk("lat_ovf", ovf32, 0);
    @(posedge clk); #1;
    chk("lat_pulse_end", out_valid32, 0);

    // Streamed table, out_ready held high
    mon_en = 1'b1;
    foreach (vq[i]) begin
      for (int g = 0; g < vq[i].gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      apply(vq[i]);
      if (vq[i].last) push_exp(vq[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    mon_en = 1'b0;

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    apply(b1024(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    apply(b856(1'b1));
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", in_ready32, 0);
      chk("bp_valid", out_valid32, 1);
      chk("bp_value32", out_value32, 1024);
      chk("bp_value16", out_value16, 1024);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready32, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_consumed", out_valid32, 0);
    @(posedge clk); #1;
    chk("bp_next_valid", out_valid32, 1);
    chk("bp_next_value", out_value32, 856);
    @(posedge clk); #1;
    chk("bp_next_end", out_valid32, 0);

    // Reset mid-group; the beat presented during reset carries last and must vanish
    mon_en = 1'b1;
    @(negedge clk);
    apply(b1024(1'b0));
    @(negedge clk);
    apply(b1024(1'b0));
    @(negedge clk);
    rst = 1'b1;
    apply(b1024(1'b1));
    @(negedge clk);
    rst = 1'b0;
    apply(b1024(1'b1));
    push_exp(b1024(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    mon_en = 1'b0;

    // Reset mid-stall with a saturated 16-bit result pending
    @(negedge clk);
    out_ready = 1'b0;
    apply(b_all14(1'b0, 1'b0));
    @(negedge clk);
    apply(b856(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ms_valid", out_valid32, 1);
    chk("ms_value32", out_value32, 263000);
    chk("ms_value16", out_value16, 32767);
    chk("ms_ovf16", ovf16, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ms_rst_valid", out_valid32, 0);
    chk("ms_rst_value", out_value32, 0);
    chk("ms_rst_ovf16", ovf16, 0);
    chk("ms_rst_ready", in_ready32, 1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ms_no_pulse", out_valid32, 0);
    mon_en = 1'b1;
    @(negedge clk);
    apply(b1024(1'b1));
    push_exp(b1024(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
